fetch_responder: RTL and testbench

- Responder end of the instruction-fetch interface driven by the CPU core: it accepts `addr`/`read_en` and returns `data`/`stall`.
- Holds one line buffer of LINE_WORDS instruction words.
- On a miss, it fills the line from a slower backing memory over a valid-handshake port, one word per beat.
- It sits between the core's fetch port and instruction memory, replacing a zero-latency array with a realistic, stalling responder.

---
 rtl/fetch_responder.sv | 121 ++++++++++++
 tb/tb_fetch_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_responder.sv
// fetch_responder: single-line instruction fetch buffer sitting between the core's
// fetch port and a slower backing memory. Misses refill the whole line one word per
// mem_valid beat; data/stall are combinational from the buffered line.
// Optional feature macro: EARLY_RESTART_EN (critical-word-first fill plus hits from a
// partially filled line).
module fetch_responder #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_BITS  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 read_en,
    output logic [31:0]          data,
    output logic                 stall,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_rdata
);
    localparam int OFF      = $clog2(LINE_WORDS);
    localparam int TAG_BITS = ADDR_BITS - OFF - 2;
    localparam logic [OFF:0] LAST_BEAT = (OFF+1)'(LINE_WORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [31:0]           words [LINE_WORDS];
    logic [TAG_BITS-1:0]   tag;
    logic                  line_valid;
    logic [LINE_WORDS-1:0] wvalid;
    logic [0:0]            state;
    logic [OFF-1:0]        cnt;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [OFF:0]          done_cnt;

    logic [OFF-1:0]        req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit;
    logic                  partial_hit;
    logic                  served;
    logic                  beat;
    logic [OFF-1:0]        start_beat;
    logic                  unused_addr_bits;

    assign req_index        = addr[OFF+1:2];
    assign req_tag          = addr[ADDR_BITS-1:OFF+2];
    assign unused_addr_bits = ^addr[1:0];

    assign hit    = read_en & line_valid & (tag == req_tag);
    assign beat   = (state == FILL) & mem_valid;
    assign served = hit | partial_hit;

`ifdef EARLY_RESTART_EN
    // Words already delivered for the line being filled can be served before the
    // line completes, and the fill begins at the word the core actually asked for.
    assign partial_hit = read_en & (state == FILL) & (fill_tag == req_tag) & wvalid[req_index];
    assign start_beat  = req_index;
`else
    logic unused_wvalid;

    assign partial_hit  = 1'b0;
    assign start_beat   = '0;
    assign unused_wvalid = ^wvalid;
`endif

    // Beat request is simply "a fill is in progress"; the address walks the line via cnt.
    assign mem_req  = (state == FILL);
    assign mem_addr = (state == FILL) ? {fill_tag, cnt, 2'b00} : '0;

    // Fetch port: zero with no request, buffered word when available, stall otherwise.
    always_comb begin
        data  = 32'd0;
        stall = 1'b0;
        if (read_en) begin
            if (served) begin
                data = words[req_index];
            end else begin
                stall = 1'b1;
            end
        end
    end

    // Control FSM: start a fill on a miss, count accepted beats, publish the line when done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            line_valid <= 1'b0;
            wvalid     <= '0;
            cnt        <= '0;
            done_cnt   <= '0;
            tag        <= '0;
            fill_tag   <= '0;
        end else if (state == IDLE) begin
            if (read_en && !hit) begin
                fill_tag   <= req_tag;
                line_valid <= 1'b0;
                wvalid     <= '0;
                cnt        <= start_beat;
                done_cnt   <= '0;
                state      <= FILL;
            end
        end else if (mem_valid) begin
            wvalid[cnt] <= 1'b1;
            cnt         <= cnt + OFF'(1);
            done_cnt    <= done_cnt + (OFF+1)'(1);
            if (done_cnt == LAST_BEAT) begin
                line_valid <= 1'b1;
                tag        <= fill_tag;
                state      <= IDLE;
            end
        end
    end

    // Line storage: capture each returned word at the slot the current beat targets.
    always_ff @(posedge clk) begin
        if (!reset && beat) begin
            words[cnt] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: randomized self-checking bench for fetch_responder.
// The reference model tracks the line at transaction level (which line is valid,
// which words of the in-flight fill have arrived, the queue of beats still owed)
// and takes expected words from its own backing-memory function.
// Follows EARLY_RESTART_EN when the macro is defined for the build.
module tb_fetch_responder;
    localparam int LW  = 4;
    localparam int AB  = 64;
    localparam int OFF = $clog2(LW);
`ifdef EARLY_RESTART_EN
    localparam bit ER = 1'b1;
`else
    localparam bit ER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AB-1:0] addr = '0;
    logic          read_en = 1'b0;
    logic [31:0]   data;
    logic          stall;
    logic          mem_req;
    logic [AB-1:0] mem_addr;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit              m_filling = 1'b0;
    bit              m_line_valid = 1'b0;
    longint unsigned m_line_tag = 0;
    longint unsigned m_fill_tag = 0;
    bit              m_arrived [LW];
    int              m_beats [$];
    int unsigned     mem_over [longint unsigned];

    fetch_responder #(.LINE_WORDS(LW), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset), .addr(addr), .read_en(read_en),
        .data(data), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint unsigned tag_of(input longint unsigned a);
        return a >> (OFF + 2);
    endfunction

    function automatic int idx_of(input longint unsigned a);
        return int'((a >> 2) % LW);
    endfunction

    function automatic logic [31:0] mem_word(input longint unsigned a);
        longint unsigned w;
        w = a & ~64'h3;
        if (mem_over.exists(w)) return mem_over[w];
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit m_avail(input longint unsigned a);
        if (m_line_valid && m_line_tag == tag_of(a)) return 1'b1;
        if (ER && m_filling && m_fill_tag == tag_of(a) && m_arrived[idx_of(a)]) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, report what the model expects for this cycle,
    // then advance the model across the coming rising edge.
    task automatic applyStimulus(input bit rst, input bit re, input longint unsigned a, input bit mv,
                                 output bit e_stall, output logic [31:0] e_data,
                                 output bit e_req, output logic [AB-1:0] e_maddr);
        @(negedge clk);
        e_req   = m_filling;
        e_maddr = m_filling ? ((m_fill_tag << (OFF + 2)) + 64'(m_beats[0]) * 4) : '0;
        if (!re) begin
            e_stall = 1'b0;
            e_data  = 32'd0;
        end else if (m_avail(a)) begin
            e_stall = 1'b0;
            e_data  = mem_word(a);
        end else begin
            e_stall = 1'b1;
            e_data  = 32'd0;
        end
        reset     = rst;
        read_en   = re;
        addr      = a;
        mem_valid = mv;
        mem_rdata = (m_filling && mv) ? mem_word(e_maddr) : $urandom;
        #1;
        if (rst) begin
            m_filling    = 1'b0;
            m_line_valid = 1'b0;
            m_beats.delete();
            foreach (m_arrived[i]) m_arrived[i] = 1'b0;
        end else if (!m_filling) begin
            if (re && !(m_line_valid && m_line_tag == tag_of(a))) begin
                int start;
                start        = ER ? idx_of(a) : 0;
                m_filling    = 1'b1;
                m_fill_tag   = tag_of(a);
                m_line_valid = 1'b0;
                foreach (m_arrived[i]) m_arrived[i] = 1'b0;
                m_beats.delete();
                for (int k = 0; k < LW; k++) m_beats.push_back((start + k) % LW);
            end
        end else if (mv) begin
            m_arrived[m_beats[0]] = 1'b1;
            void'(m_beats.pop_front());
            if (m_beats.size() == 0) begin
                m_filling    = 1'b0;
                m_line_valid = 1'b1;
                m_line_tag   = m_fill_tag;
            end
        end
    endtask

    task automatic test_reset();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(c < 2, 1'b0, 64'h0, 1'b0, es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL reset_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL reset_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
        end
    endtask

    task automatic test_basic_fill();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        longint unsigned rd [4] = '{64'h1000, 64'h1008, 64'h1004, 64'h100C};
        int c = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 64'h1000, m_filling && (c % 3 == 2), es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL basic_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL basic_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while (m_filling && c < 100);
        n_cmp++;
        if (m_filling) begin
            n_bad++;
            $display("[TB] FAIL basic_timeout got filling=1 want filling=0");
        end
        foreach (rd[i]) begin
            applyStimulus(1'b0, 1'b1, rd[i], 1'b0, es, ed, er, ea);
            n_cmp++;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL basic_hit addr=%h got stall=%b data=%h want stall=%b data=%h", rd[i], stall, data, es, ed);
            end
        end
    endtask

    task automatic test_miss_refill();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        longint unsigned lines [2] = '{64'h1010, 64'h1004};
        foreach (lines[l]) begin
            int c = 0;
            do begin
                applyStimulus(1'b0, 1'b1, lines[l], m_filling && ($urandom_range(0, 2) == 0), es, ed, er, ea);
                n_cmp += 2;
                if (stall !== es || data !== ed) begin
                    n_bad++;
                    $display("[TB] FAIL refill_out line=%0d got stall=%b data=%h want stall=%b data=%h", l, stall, data, es, ed);
                end
                if (mem_req !== er || mem_addr !== ea) begin
                    n_bad++;
                    $display("[TB] FAIL refill_mem line=%0d got req=%b addr=%h want req=%b addr=%h", l, mem_req, mem_addr, er, ea);
                end
                c++;
            end while (m_filling && c < 200);
            n_cmp++;
            if (m_filling) begin
                n_bad++;
                $display("[TB] FAIL refill_timeout line=%0d got filling=1 want filling=0", l);
            end
            for (int i = 0; i < LW; i++) begin
                longint unsigned a = (lines[l] & ~64'(LW * 4 - 1)) + 64'(i * 4);
                applyStimulus(1'b0, 1'b1, a, 1'b0, es, ed, er, ea);
                n_cmp++;
                if (stall !== es || data !== ed) begin
                    n_bad++;
                    $display("[TB] FAIL refill_hit addr=%h got stall=%b data=%h want stall=%b data=%h", a, stall, data, es, ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        int c = 0;
        // Run until two beats have been accepted, then reset with a beat still arriving.
        do begin
            applyStimulus(1'b0, 1'b1, 64'h2000, m_filling && (c % 2 == 1), es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL midrst_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL midrst_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while (!(m_filling && m_beats.size() == LW - 2) && c < 50);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k == 0, 1'b0, 64'h2000, 1'b1, es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL midrst_late_out k=%0d got stall=%b data=%h want stall=%b data=%h", k, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL midrst_late_mem k=%0d got req=%b addr=%h want req=%b addr=%h", k, mem_req, mem_addr, er, ea);
            end
        end
        c = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 64'h2000, m_filling && ($urandom_range(0, 1) == 0), es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL midrst_refill_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL midrst_refill_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while ((m_filling || c < 2) && c < 200);
        n_cmp++;
        if (m_filling) begin
            n_bad++;
            $display("[TB] FAIL midrst_timeout got filling=1 want filling=0");
        end
    endtask

    task automatic test_read_en_low();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        int c = 0;
        // Idle beats and reset with no fetch: nothing may become valid.
        for (int k = 0; k < 12; k++) begin
            applyStimulus(k == 6, 1'b0, 64'h1000 + 64'($urandom_range(0, 255) << 2), $urandom_range(0, 1) == 1,
                          es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL rdlow_out k=%0d got stall=%b data=%h want stall=%b data=%h", k, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL rdlow_mem k=%0d got req=%b addr=%h want req=%b addr=%h", k, mem_req, mem_addr, er, ea);
            end
        end
        do begin
            applyStimulus(1'b0, (c % 5) != 3, 64'h1000, m_filling && ($urandom_range(0, 2) != 0), es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL rdlow_fill_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL rdlow_fill_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while ((m_filling || c < 2) && c < 200);
    endtask

    task automatic test_early_restart();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        int c = 0;
        // Ask for the last word, then switch to the first word of the same line mid-fill.
        do begin
            applyStimulus(1'b0, 1'b1, (c <= 2) ? 64'h300C : 64'h3000, m_filling && (c % 2 == 1),
                          es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL early_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL early_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while ((m_filling || c < 2) && c < 100);
        n_cmp++;
        if (m_filling) begin
            n_bad++;
            $display("[TB] FAIL early_timeout got filling=1 want filling=0");
        end
    endtask

    task automatic test_back_to_back();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        longint unsigned base;
        longint unsigned a;
        int c = 0;
        int req_cycles = 0;
        base = 64'h4000 + (64'($urandom_range(0, 255)) << 4);
        a    = base + (64'($urandom_range(0, LW - 1)) << 2);
        do begin
            applyStimulus(1'b0, 1'b1, a, m_filling, es, ed, er, ea);
            if (mem_req === 1'b1) req_cycles++;
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL b2b_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL b2b_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
            c++;
        end while (m_filling && c < 40);
        n_cmp++;
        if (req_cycles != LW) begin
            n_bad++;
            $display("[TB] FAIL b2b_fill_len got %0d req cycles want %0d", req_cycles, LW);
        end
        for (int i = 0; i < LW; i++) begin
            applyStimulus(1'b0, 1'b1, base + 64'(i * 4), 1'b0, es, ed, er, ea);
            n_cmp++;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL b2b_hit idx=%0d got stall=%b data=%h want stall=%b data=%h", i, stall, data, es, ed);
            end
        end
    endtask

    task automatic test_random();
        bit es, er;
        logic [31:0] ed;
        logic [AB-1:0] ea;
        for (int c = 0; c < 400; c++) begin
            longint unsigned a;
            a = 64'h5000 + (64'($urandom_range(0, 3)) << 4) + (64'($urandom_range(0, 3)) << 2);
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                          es, ed, er, ea);
            n_cmp += 2;
            if (stall !== es || data !== ed) begin
                n_bad++;
                $display("[TB] FAIL rand_out cyc=%0d got stall=%b data=%h want stall=%b data=%h", c, stall, data, es, ed);
            end
            if (mem_req !== er || mem_addr !== ea) begin
                n_bad++;
                $display("[TB] FAIL rand_mem cyc=%0d got req=%b addr=%h want req=%b addr=%h", c, mem_req, mem_addr, er, ea);
            end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        mem_over[64'h1000] = 32'hA0;
        mem_over[64'h1004] = 32'hA1;
        mem_over[64'h1008] = 32'hA2;
        mem_over[64'h100C] = 32'hA3;
        foreach (m_arrived[i]) m_arrived[i] = 1'b0;
        $display("[TB] start, early restart build = %0d", ER);
        test_reset();
        test_basic_fill();
        test_miss_refill();
        test_reset_mid_fill();
        test_read_en_low();
        test_early_restart();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
